// File: rtl/float_pkg.sv
// Shared single-precision definitions for the fixed-to-float converter and the adder.
package float_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MAN_W  = FRAC_W + 1;
  localparam int unsigned BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } fsm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_t;

  function automatic logic [31:0] pack_float(input logic s,
                                             input logic [EXP_W-1:0] e,
                                             input logic [FRAC_W-1:0] f);
    float_t r;
    r.sign = s;
    r.exp  = e;
    r.frac = f;
    return r;
  endfunction

endpackage

// File: rtl/float_unpack.sv
// Splits a packed single into sign/exponent/mantissa with hidden bit; denormals flush to zero.
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man,
  output logic             is_zero,
  output logic             is_special
);

  float_t f;

  assign f = word;

  always_comb begin
    sign       = f.sign;
    exp        = f.exp;
    is_zero    = (f.exp == '0);
    is_special = (f.exp == EXP_MAX);
    man        = is_zero ? '0 : {1'b1, f.frac};
  end

endmodule

// File: rtl/float_adder.sv
// Iterative single-precision adder: one alignment or normalisation shift per cycle,
// truncating rounding, special cases short-circuited straight to completion.
module float_adder
  import float_pkg::*;
#(
  parameter int unsigned MAX_ALIGN = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        load_new,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum
);

  localparam int unsigned CNT_W = $clog2(MAX_ALIGN + 1);
  localparam logic [CNT_W-1:0] ALIGN_CAP = CNT_W'(MAX_ALIGN);

  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W-1:0] ua_man, ub_man;
  logic             ua_zero, ub_zero, ua_spec, ub_spec;
  logic             swap;

  fsm_state_t       state, state_n;
  logic             a_sign, a_sign_n, b_sign, b_sign_n;
  logic [EXP_W-1:0] a_exp, a_exp_n, b_exp, b_exp_n;
  logic [MAN_W-1:0] a_man, a_man_n, b_man, b_man_n;
  logic [CNT_W-1:0] align_cnt, align_cnt_n;
  logic             res_sign, res_sign_n;
  logic [EXP_W-1:0] res_exp, res_exp_n;
  logic [MAN_W:0]   res_man, res_man_n;
  logic [MAN_W:0]   mag;
  logic [EXP_W-1:0] exp_inc;
  logic [31:0]      sum_q, sum_n;
  logic             done_q, done_n;

  float_unpack u_unpack_a (
    .word       (a),
    .sign       (ua_sign),
    .exp        (ua_exp),
    .man        (ua_man),
    .is_zero    (ua_zero),
    .is_special (ua_spec)
  );

  float_unpack u_unpack_b (
    .word       (b),
    .sign       (ub_sign),
    .exp        (ub_exp),
    .man        (ub_man),
    .is_zero    (ub_zero),
    .is_special (ub_spec)
  );

  assign swap    = (ub_exp > ua_exp);
  assign exp_inc = res_exp + 8'd1;

  // sum/done are written on the edge entering DONE so the pulse coincides
  // with the new result while the FSM still reports busy.
  always_comb begin
    state_n     = state;
    a_sign_n    = a_sign;
    a_exp_n     = a_exp;
    a_man_n     = a_man;
    b_sign_n    = b_sign;
    b_exp_n     = b_exp;
    b_man_n     = b_man;
    align_cnt_n = align_cnt;
    res_sign_n  = res_sign;
    res_exp_n   = res_exp;
    res_man_n   = res_man;
    mag         = '0;
    sum_n       = sum_q;
    done_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (load_new) begin
          a_sign_n    = swap ? ub_sign : ua_sign;
          a_exp_n     = swap ? ub_exp  : ua_exp;
          a_man_n     = swap ? ub_man  : ua_man;
          b_sign_n    = swap ? ua_sign : ub_sign;
          b_exp_n     = swap ? ua_exp  : ub_exp;
          b_man_n     = swap ? ua_man  : ub_man;
          align_cnt_n = '0;
          if (ua_spec || ub_spec) begin
            sum_n   = QNAN;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else if (ua_zero && ub_zero) begin
            sum_n   = '0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else if (ua_zero) begin
            sum_n   = b;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else if (ub_zero) begin
            sum_n   = a;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_ALIGN;
          end
        end
      end

      S_ALIGN: begin
        if (a_exp == b_exp) begin
          state_n = S_ADD;
        end else begin
          b_man_n     = b_man >> 1;
          b_exp_n     = b_exp + 8'd1;
          align_cnt_n = align_cnt + 1'b1;
          if (align_cnt_n == ALIGN_CAP) begin
            b_man_n = '0;
            state_n = S_ADD;
          end
        end
      end

      S_ADD: begin
        res_exp_n = a_exp;
        if (a_sign == b_sign) begin
          mag        = {1'b0, a_man} + {1'b0, b_man};
          res_sign_n = a_sign;
        end else if (a_man >= b_man) begin
          mag        = {1'b0, a_man} - {1'b0, b_man};
          res_sign_n = a_sign;
        end else begin
          mag        = {1'b0, b_man} - {1'b0, a_man};
          res_sign_n = b_sign;
        end
        res_man_n = mag;
        if (mag == '0) begin
          sum_n   = '0;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_NORM;
        end
      end

      S_NORM: begin
        if (res_man[MAN_W]) begin
          if (exp_inc == EXP_MAX) sum_n = pack_float(res_sign, EXP_MAX, '0);
          else                    sum_n = pack_float(res_sign, exp_inc, res_man[FRAC_W:1]);
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (res_man[FRAC_W]) begin
          sum_n   = pack_float(res_sign, res_exp, res_man[FRAC_W-1:0]);
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          res_man_n = {res_man[MAN_W-1:0], 1'b0};
          res_exp_n = res_exp - 8'd1;
          if (res_exp_n == '0) begin
            sum_n   = '0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else if (res_man[FRAC_W-1]) begin
            sum_n   = pack_float(res_sign, res_exp_n, {res_man[FRAC_W-2:0], 1'b0});
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end
      end

      S_DONE: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_sign    <= 1'b0;
      a_exp     <= '0;
      a_man     <= '0;
      b_sign    <= 1'b0;
      b_exp     <= '0;
      b_man     <= '0;
      align_cnt <= '0;
      res_sign  <= 1'b0;
      res_exp   <= '0;
      res_man   <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      a_sign    <= a_sign_n;
      a_exp     <= a_exp_n;
      a_man     <= a_man_n;
      b_sign    <= b_sign_n;
      b_exp     <= b_exp_n;
      b_man     <= b_man_n;
      align_cnt <= align_cnt_n;
      res_sign  <= res_sign_n;
      res_exp   <= res_exp_n;
      res_man   <= res_man_n;
      sum_q     <= sum_n;
      done_q    <= done_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign sum  = sum_q;

endmodule

// File: tb/tb_float_adder.sv
// Scoreboard bench for float_adder: directed vectors push expected sums, a monitor checks each done.
module tb_float_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        load_new;
  logic        busy, done;
  logic [31:0] sum;

  always #5 clk = ~clk;

  float_adder #(.MAX_ALIGN(26)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .load_new (load_new),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] val;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got sum %h with no pending operation", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("sum_vec%0d", e.id), sum, e.val);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_done(input int start, input int limit);
    int n;
    n = 0;
    while (n_done == start && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n_done == start) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", limit);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] want, input logic [7:0] id);
    int start;
    wait_idle();
    a        = x;
    b        = y;
    load_new = 1'b1;
    start    = n_done;
    exp_q.push_back('{id: id, val: want});
    @(negedge clk);
    load_new = 1'b0;
    a        = $urandom;
    b        = $urandom;
    check($sformatf("busy_after_capture_vec%0d", id), {31'b0, busy}, 32'h1);
    wait_done(start, 52);
    repeat (2) @(negedge clk);
    check($sformatf("sum_hold_vec%0d", id), sum, want);
    check($sformatf("busy_low_vec%0d", id), {31'b0, busy}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{a: 32'h3F800000, b: 32'h3F800000, s: 32'h40000000};
    vecs[1]  = '{a: 32'h40D00000, b: 32'h3F800000, s: 32'h40F00000};
    vecs[2]  = '{a: 32'h3FC00000, b: 32'hBFA00000, s: 32'h3E800000};
    vecs[3]  = '{a: 32'h3F800000, b: 32'hBF800000, s: 32'h00000000};
    vecs[4]  = '{a: 32'h3F800000, b: 32'h30800000, s: 32'h3F800000};
    vecs[5]  = '{a: 32'h7F7FFFFF, b: 32'h7F7FFFFF, s: 32'h7F800000};
    vecs[6]  = '{a: 32'h7F800000, b: 32'h3F800000, s: 32'h7FC00000};
    vecs[7]  = '{a: 32'h00000000, b: 32'hC0490FDB, s: 32'hC0490FDB};
    vecs[8]  = '{a: 32'hBF800000, b: 32'hBF800000, s: 32'hC0000000};
    vecs[9]  = '{a: 32'h00000001, b: 32'h3F800000, s: 32'h3F800000};
    vecs[10] = '{a: 32'h3F800000, b: 32'h40D00000, s: 32'h40F00000};
    vecs[11] = '{a: 32'hBFC00000, b: 32'h3FA00000, s: 32'hBE800000};

    rst_n    = 1'b1;
    load_new = 1'b0;
    a        = '0;
    b        = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sum", sum, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].s, 8'(i));

    // load_new while busy must not re-sample operands or start a second operation
    begin
      int start;
      wait_idle();
      a        = 32'h3F800000;
      b        = 32'h3F800000;
      load_new = 1'b1;
      start    = n_done;
      exp_q.push_back('{id: 8'd20, val: 32'h40000000});
      @(negedge clk);
      load_new = 1'b0;
      @(negedge clk);
      a        = 32'h40D00000;
      b        = 32'hBF800000;
      load_new = 1'b1;
      repeat (2) @(negedge clk);
      load_new = 1'b0;
      wait_done(start, 52);
      repeat (40) @(negedge clk);
      check("busy_ignore_sum", sum, 32'h40000000);
    end

    // asynchronous reset mid-ALIGN aborts with no result delivered
    wait_idle();
    a        = 32'h3F800000;
    b        = 32'h30800000;
    load_new = 1'b1;
    @(negedge clk);
    load_new = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_sum_stays", sum, 32'h0);

    run_op(32'h3FC00000, 32'hBFA00000, 32'h3E800000, 8'd30);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
